// File: rtl/toggle_event_decoder_pkg.sv
// Shared definitions for the toggle-event link: FSM state encoding and
// default synchroniser depth used by both transmitter and receiver sides.
package toggle_event_decoder_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_OVERRUN = 2'd2
  } state_e;

endpackage

// File: rtl/toggle_event_decoder_sync_chain.sv
// Falling-edge multi-flop synchroniser with asynchronous active-low reset to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-encoded event link: synchronise, recover one pulse
// per level change, count events and track pending/overrun until acknowledged.
module toggle_event_decoder
  import toggle_event_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Tog_in,
  input  logic             Ack,
  input  logic             Clr_cnt,
  output logic             Pulse_out,
  output logic             Evt_pending,
  output logic             Ovf,
  output logic [CNT_W-1:0] Evt_count
);

  logic             tog_s;
  logic             vld_s;
  logic             prev_q, prev_d;
  logic             primed_q, primed_d;
  logic             pulse_q, pulse_d;
  logic             pending_q, pending_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_data (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .d     (Tog_in),
    .q     (tog_s)
  );

  // A constant 1 pushed through an identical chain marks when tog_s first
  // carries a real sample rather than the reset value.
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_valid (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .d     (1'b1),
    .q     (vld_s)
  );

  always_comb begin
    prev_d   = tog_s;
    primed_d = primed_q | vld_s;
    pulse_d  = primed_q & (tog_s ^ prev_q);

    cnt_d = cnt_q;
    if (Clr_cnt) begin
      cnt_d = '0;
    end else if (pulse_d) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Ack always retires the older event; a coincident pulse becomes the new one.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pulse_d) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (Ack && !pulse_d)      state_d = ST_IDLE;
        else if (!Ack && pulse_d) state_d = ST_OVERRUN;
      end
      ST_OVERRUN: begin
        if (Ack) state_d = pulse_d ? ST_PENDING : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = (state_d != ST_IDLE);
    ovf_d     = (state_d == ST_OVERRUN);
  end

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev_q    <= 1'b0;
      primed_q  <= 1'b0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
    end else begin
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign Pulse_out   = pulse_q;
  assign Evt_pending = pending_q;
  assign Ovf         = ovf_q;
  assign Evt_count   = cnt_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed and randomised checks of toggle_event_decoder against an
// event-queue reference model (unacknowledged-event count, scheduled pulses).
module tb_toggle_event_decoder;

  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int LAT  = SYNC + 1;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Tog_in = 1'b1;
  logic          Ack = 1'b0;
  logic          Clr_cnt = 1'b0;
  logic          Pulse_out;
  logic          Evt_pending;
  logic          Ovf;
  logic [CW-1:0] Evt_count;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int exp_cnt = 0;
  int unacked = 0;
  int sched[$];

  toggle_event_decoder #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Tog_in      (Tog_in),
    .Ack         (Ack),
    .Clr_cnt     (Clr_cnt),
    .Pulse_out   (Pulse_out),
    .Evt_pending (Evt_pending),
    .Ovf         (Ovf),
    .Evt_count   (Evt_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int p, input int c, input int pend, input int o);
    chk({tag, "_pulse"},   int'(Pulse_out),   p);
    chk({tag, "_count"},   int'(Evt_count),   c);
    chk({tag, "_pending"}, int'(Evt_pending), pend);
    chk({tag, "_ovf"},     int'(Ovf),         o);
  endtask

  // One clock cycle: drive at rising edge, let the DUT update on the falling
  // edge, then advance the model and compare.
  task automatic cyc(input bit tg, input bit ack, input bit clr);
    int exp_pulse;
    @(posedge Clk);
    if (tg) begin
      Tog_in = ~Tog_in;
      sched.push_back(edge_n + LAT);
    end
    Ack = ack;
    Clr_cnt = clr;
    @(negedge Clk);
    #1;
    edge_n++;
    exp_pulse = 0;
    if (sched.size() > 0 && sched[0] == edge_n) begin
      exp_pulse = 1;
      void'(sched.pop_front());
    end
    exp_cnt = clr ? 0 : (exp_cnt + exp_pulse) % (1 << CW);
    unacked = (ack ? 0 : unacked) + exp_pulse;
    chk_all("cyc", exp_pulse, exp_cnt, int'(unacked > 0), int'(unacked > 1));
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int cycles, input bit tog_during);
    @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0);
    sched.delete();
    unacked = 0;
    exp_cnt = 0;
    Ack = 1'b0;
    Clr_cnt = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clk);
      if (tog_during) Tog_in = ~Tog_in;
      @(negedge Clk);
      #1;
      chk_all("in_rst", 0, 0, 0, 0);
    end
    @(posedge Clk);
    Rst_n = 1'b1;
    quiet(4);
  endtask

  initial begin
    int since;
    bit tg;

    // Power-up reset with the line parked high: no spurious event after release.
    #1;
    chk_all("por", 0, 0, 0, 0);
    repeat (3) @(negedge Clk);
    @(posedge Clk);
    Rst_n = 1'b1;
    quiet(10);
    chk("parked_count", int'(Evt_count), 0);

    // Single event, acknowledged; then a 0->1 toggle with exact latency.
    cyc(1'b1, 1'b0, 1'b0);
    quiet(3);
    cyc(1'b0, 1'b1, 1'b0);
    quiet(2);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lat_before", int'(Pulse_out), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lat_edge3", int'(Pulse_out), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lat_one_cycle", int'(Pulse_out), 0);
    chk("lat_count", int'(Evt_count), 2);
    chk("lat_pending", int'(Evt_pending), 1);
    cyc(1'b0, 1'b1, 1'b0);

    // Two toggles six cycles apart without Ack -> overrun; Ack clears both.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    quiet(5);
    cyc(1'b1, 1'b0, 1'b0);
    quiet(5);
    chk("ovr_ovf", int'(Ovf), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("ovr_ack_ovf", int'(Ovf), 0);
    chk("ovr_ack_pending", int'(Evt_pending), 0);
    chk("ovr_ack_count", int'(Evt_count), 2);

    // Ack coincident with a pulse while pending: stays pending, no overrun.
    cyc(1'b1, 1'b0, 1'b0);
    quiet(4);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("coinc_pending", int'(Evt_pending), 1);
    chk("coinc_ovf", int'(Ovf), 0);
    chk("coinc_count", int'(Evt_count), 4);
    cyc(1'b0, 1'b1, 1'b0);

    // Counter wrap with a 4-bit counter, then Clr_cnt coincident with a pulse.
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      quiet(3);
    end
    chk("wrap_end", int'(Evt_count), 1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("clr_pulse_seen", int'(Pulse_out), 1);
    chk("clr_wins", int'(Evt_count), 0);
    cyc(1'b0, 1'b1, 1'b0);

    // Reset mid-overrun: outputs drop at once; toggles during reset are discarded.
    cyc(1'b1, 1'b0, 1'b0);
    quiet(4);
    cyc(1'b1, 1'b0, 1'b0);
    quiet(4);
    chk("pre_rst_ovf", int'(Ovf), 1);
    do_reset(3, 1'b1);
    quiet(6);
    chk("post_rst_count", int'(Evt_count), 0);

    // Randomised traffic respecting the minimum hold time of the source.
    since = LAT;
    for (int i = 0; i < 400; i++) begin
      tg = (since >= LAT) && ($urandom_range(3) == 0);
      since = tg ? 1 : since + 1;
      cyc(tg, ($urandom_range(3) == 0), ($urandom_range(15) == 0));
    end
    quiet(LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
